mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one piplined_integer_multiplier between two independent requesters.
- Performs round-robin arbitration and registers the granted operands into the multiplier's gx/gy/ex/ey inputs.
- Tracks the owner of each in-flight operation with a tag shift register matched to the multiplier latency.
- Steers each product back to the requester that issued it. Sits directly in front of the multiplier in the arithmetic datapath.

Parameters:
LAT, 3, multiplier latency in cycles: mul_gx..mul_ey registered -> mul_product valid (must equal the pipeline depth of the multiplier instance)

Ports:
clk_in  in  1  system clock, all state on rising edge
rst_in  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 granted this cycle (combinational)
req0_gx  in  11  requester 0 operand x significand
req0_gy  in  11  requester 0 operand y significand
req0_ex  in  5  requester 0 operand x exponent
req0_ey  in  5  requester 0 operand y exponent
req1_valid, req1_ready, req1_gx, req1_gy, req1_ex, req1_ey  same as requester 0, for requester 1
mul_gx  out  11  registered operand to multiplier
mul_gy  out  11  registered operand to multiplier
mul_ex  out  5  registered operand to multiplier
mul_ey  out  5  registered operand to multiplier
mul_product  in  22  product from multiplier
rsp0_valid  out  1  one-cycle pulse, result for requester 0
rsp0_product  out  22  result for requester 0 (valid only with rsp0_valid)
rsp1_valid  out  1  one-cycle pulse, result for requester 1
rsp1_product  out  22  result for requester 1
busy  out  1  any operation in flight

Behaviour:
- Reset (rst_in=0, asynchronous):
  - mul_gx/gy/ex/ey=0, rsp*_valid=0, rsp*_product=0, busy=0.
  - All tag-pipeline entries cleared; round-robin pointer = requester 0 preferred.
- Arbitration is combinational each cycle:
  - Only reqN_valid -> grant N.
  - Both valid -> grant the requester indicated by the pointer.
  - Neither valid -> no grant.
  - reqN_ready = grant N. The ready signals are never both 1. Ready does not depend on pipeline occupancy, so the multiplier accepts one operation per cycle.
- Handshake: reqN_valid & reqN_ready at rising edge T.
  - Operands are captured into mul_* at T.
  - Pointer updates to the other requester (1-N) only when both were valid at T. With a single requester, the pointer is unchanged.
  - Requesters hold valid and operands stable until ready.
- No grant at T: mul_* hold their previous values. The tag entry pushed for this cycle is invalid.
- Tag pipeline: LAT+1 entries of {valid, owner}, shifted every cycle unconditionally.
  - Entry 0 is loaded at the handshake edge.
  - The entry reaching stage LAT+1 qualifies the mul_product sample.
- Response timing:
  - Handshake at edge T -> rspN_valid=1 and rspN_product = registered mul_product during the cycle after edge T+LAT+1.
  - Total request-to-response latency: LAT+2 edges.
  - Responses are registered, pulse for one cycle, and have no backpressure; the requester must accept.
  - rsp0_valid and rsp1_valid are never both 1.
  - rspN_product holds its last value when not valid.
- Back-to-back handshakes on consecutive edges produce responses on consecutive cycles, in issue order, each tagged to its own owner.
- busy = OR of all tag valid bits plus the response-stage valid.
- Reset mid-operation discards all in-flight tags. After reset deasserts, no rsp*_valid fires for operations issued before reset, even though the multiplier output may still carry stale products.
- Arithmetic: the block performs none. It passes products through unmodified at 22 bits and passes operands through unmodified.

Test Plan:
- Reset check: rst_in low mid-run with 3 operations in flight -> all outputs 0 immediately. After release, no rsp pulses for the next LAT+3 cycles.
- Single request: req0 gx=11'b1010, gy=11'b0010, ex=1, ey=2, valid for one cycle.
  - req0_ready=1 same cycle; mul_* equal the operands after that edge.
  - rsp0_valid pulses exactly LAT+2 edges after the handshake, with rsp0_product equal to the multiplier's product for those operands.
  - rsp1_valid stays 0.
- Contention: req0 and req1 held valid for 6 cycles.
  - Grants alternate 0,1,0,1,0,1, starting with 0 after reset.
  - Responses alternate rsp0/rsp1 on 6 consecutive cycles.
  - Each requester receives the product of its own operands (req1: gx=3, gy=5 -> product of 15 scaled per the multiplier).
- Single-requester streaming: req1 valid for 4 consecutive cycles with distinct operands, req0 idle.
  - req1_ready=1 on all 4 cycles.
  - 4 consecutive rsp1 pulses in issue order; the pointer is unchanged, so a subsequent simultaneous request grants req0 first.
- Gaps: req0 issues at cycles 0 and 2, req1 at cycle 1 -> responses 0,1,0 on consecutive cycles starting LAT+2 edges after the first handshake. busy deasserts on the cycle after the last response.
- Hold: req1_valid asserted while req0 wins arbitration -> req1_ready=0 that cycle and granted next cycle. Operands are unchanged in mul_* until req1's grant edge.

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_share_arbiter_if
//  Brief    : Requester, response and multiplier-side signals of the shared
//             multiplier arbiter, grouped as one bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_share_arbiter_if;
   // requester 0
   logic        req0_valid;
   logic        req0_ready;
   logic [10:0] req0_gx;
   logic [10:0] req0_gy;
   logic [4:0]  req0_ex;
   logic [4:0]  req0_ey;
   // requester 1
   logic        req1_valid;
   logic        req1_ready;
   logic [10:0] req1_gx;
   logic [10:0] req1_gy;
   logic [4:0]  req1_ex;
   logic [4:0]  req1_ey;
   // multiplier side
   logic [10:0] mul_gx;
   logic [10:0] mul_gy;
   logic [4:0]  mul_ex;
   logic [4:0]  mul_ey;
   logic [21:0] mul_product;
   // responses
   logic        rsp0_valid;
   logic [21:0] rsp0_product;
   logic        rsp1_valid;
   logic [21:0] rsp1_product;
   logic        busy;

   // arbiter view
   modport slave (
      input  req0_valid, req0_gx, req0_gy, req0_ex, req0_ey,
      input  req1_valid, req1_gx, req1_gy, req1_ex, req1_ey,
      input  mul_product,
      output req0_ready, req1_ready,
      output mul_gx, mul_gy, mul_ex, mul_ey,
      output rsp0_valid, rsp0_product, rsp1_valid, rsp1_product, busy
   );

   // requester / multiplier environment view
   modport master (
      output req0_valid, req0_gx, req0_gy, req0_ex, req0_ey,
      output req1_valid, req1_gx, req1_gy, req1_ex, req1_ey,
      output mul_product,
      input  req0_ready, req1_ready,
      input  mul_gx, mul_gy, mul_ex, mul_ey,
      input  rsp0_valid, rsp0_product, rsp1_valid, rsp1_product, busy
   );
endinterface
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_share_arbiter
//  Brief    : Round-robin sharing of one pipelined multiplier between two
//             requesters; a tag shift register routes each product back to
//             the requester that issued it.
//  Revision : 1.0  initial release
// ============================================================================
module mul_share_arbiter #(
   parameter int LAT = 3
) (
   input  wire logic             clk_in,
   input  wire logic             rst_in,
   mul_share_arbiter_if.slave    bus
);

   localparam int DEPTH = LAT + 1;

   logic             grant0;
   logic             grant1;
   logic             ptr_q,          ptr_d;
   logic [10:0]      mul_gx_q,       mul_gx_d;
   logic [10:0]      mul_gy_q,       mul_gy_d;
   logic [4:0]       mul_ex_q,       mul_ex_d;
   logic [4:0]       mul_ey_q,       mul_ey_d;
   logic [DEPTH-1:0] tag_vld_q,      tag_vld_d;
   logic [DEPTH-1:0] tag_own_q,      tag_own_d;
   logic             rsp0_valid_q,   rsp0_valid_d;
   logic             rsp1_valid_q,   rsp1_valid_d;
   logic [21:0]      rsp0_product_q, rsp0_product_d;
   logic [21:0]      rsp1_product_q, rsp1_product_d;

   // Round-robin grant: ptr_q=0 favours requester 0 when both are valid
   always_comb begin
      grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
      grant1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);
   end

   // Next state: pointer, operand registers, tag pipeline and response stage
   always_comb begin
      ptr_d          = ptr_q;
      mul_gx_d       = mul_gx_q;
      mul_gy_d       = mul_gy_q;
      mul_ex_d       = mul_ex_q;
      mul_ey_d       = mul_ey_q;
      rsp0_product_d = rsp0_product_q;
      rsp1_product_d = rsp1_product_q;

      // pointer only moves when there was actual contention
      if (bus.req0_valid && bus.req1_valid) begin
         ptr_d = ~ptr_q;
      end

      if (grant0) begin
         mul_gx_d = bus.req0_gx;
         mul_gy_d = bus.req0_gy;
         mul_ex_d = bus.req0_ex;
         mul_ey_d = bus.req0_ey;
      end else if (grant1) begin
         mul_gx_d = bus.req1_gx;
         mul_gy_d = bus.req1_gy;
         mul_ex_d = bus.req1_ex;
         mul_ey_d = bus.req1_ey;
      end

      // tags shift every cycle; an idle cycle pushes an invalid entry
      tag_vld_d = {tag_vld_q[DEPTH-2:0], grant0 | grant1};
      tag_own_d = {tag_own_q[DEPTH-2:0], grant1};

      // the last tag stage lines up with the product leaving the multiplier
      rsp0_valid_d = tag_vld_q[DEPTH-1] & ~tag_own_q[DEPTH-1];
      rsp1_valid_d = tag_vld_q[DEPTH-1] &  tag_own_q[DEPTH-1];
      if (rsp0_valid_d) begin
         rsp0_product_d = bus.mul_product;
      end
      if (rsp1_valid_d) begin
         rsp1_product_d = bus.mul_product;
      end
   end

   // State registers; reset drops every in-flight tag
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ptr_q          <= 1'b0;
         mul_gx_q       <= '0;
         mul_gy_q       <= '0;
         mul_ex_q       <= '0;
         mul_ey_q       <= '0;
         tag_vld_q      <= '0;
         tag_own_q      <= '0;
         rsp0_valid_q   <= 1'b0;
         rsp1_valid_q   <= 1'b0;
         rsp0_product_q <= '0;
         rsp1_product_q <= '0;
      end else begin
         ptr_q          <= ptr_d;
         mul_gx_q       <= mul_gx_d;
         mul_gy_q       <= mul_gy_d;
         mul_ex_q       <= mul_ex_d;
         mul_ey_q       <= mul_ey_d;
         tag_vld_q      <= tag_vld_d;
         tag_own_q      <= tag_own_d;
         rsp0_valid_q   <= rsp0_valid_d;
         rsp1_valid_q   <= rsp1_valid_d;
         rsp0_product_q <= rsp0_product_d;
         rsp1_product_q <= rsp1_product_d;
      end
   end

   assign bus.req0_ready   = grant0;
   assign bus.req1_ready   = grant1;
   assign bus.mul_gx       = mul_gx_q;
   assign bus.mul_gy       = mul_gy_q;
   assign bus.mul_ex       = mul_ex_q;
   assign bus.mul_ey       = mul_ey_q;
   assign bus.rsp0_valid   = rsp0_valid_q;
   assign bus.rsp1_valid   = rsp1_valid_q;
   assign bus.rsp0_product = rsp0_product_q;
   assign bus.rsp1_product = rsp1_product_q;
   assign bus.busy         = (|tag_vld_q) | rsp0_valid_q | rsp1_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_share_arbiter
//  Brief    : Directed bench for mul_share_arbiter with a 3-stage multiplier
//             model (product = gx * gy) behind it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_share_arbiter;

   logic clk_in;
   logic rst_in;
   int   n_total;
   int   n_pass;

   mul_share_arbiter_if bus ();

   mul_share_arbiter #(.LAT(3)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // three-stage multiplier model
   logic [21:0] p1, p2, p3;
   always_ff @(posedge clk_in) begin
      p1 <= {11'b0, bus.mul_gx} * {11'b0, bus.mul_gy};
      p2 <= p1;
      p3 <= p2;
   end
   assign bus.mul_product = p3;

   // requester operands and expected multiplier-side operands
   logic [10:0] a0x, a0y, a1x, a1y, emx, emy;
   logic [4:0]  a0e, a0f, a1e, a1f, eme, emf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic set0(input logic [10:0] gx, input logic [10:0] gy, input logic [4:0] ex, input logic [4:0] ey);
      a0x = gx; a0y = gy; a0e = ex; a0f = ey;
   endtask

   task automatic set1(input logic [10:0] gx, input logic [10:0] gy, input logic [4:0] ex, input logic [4:0] ey);
      a1x = gx; a1y = gy; a1e = ex; a1f = ey;
   endtask

   // One cycle: drive at negedge, check readies, cross the edge, check outputs
   task automatic run_cycle(input logic v0, input logic v1, input logic er0, input logic er1,
                            input logic ers0, input logic ers1, input logic [21:0] eprod,
                            input logic ebusy);
      bus.req0_valid = v0;
      bus.req0_gx = a0x; bus.req0_gy = a0y; bus.req0_ex = a0e; bus.req0_ey = a0f;
      bus.req1_valid = v1;
      bus.req1_gx = a1x; bus.req1_gy = a1y; bus.req1_ex = a1e; bus.req1_ey = a1f;
      #1;
      chk("req0_ready", 32'(bus.req0_ready), 32'(er0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(er1));
      if (er0) begin
         emx = a0x; emy = a0y; eme = a0e; emf = a0f;
      end else if (er1) begin
         emx = a1x; emy = a1y; eme = a1e; emf = a1f;
      end
      @(posedge clk_in);
      @(negedge clk_in);
      chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(ers0));
      chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(ers1));
      if (ers0) chk("rsp0_product", 32'(bus.rsp0_product), 32'(eprod));
      if (ers1) chk("rsp1_product", 32'(bus.rsp1_product), 32'(eprod));
      chk("busy", 32'(bus.busy), 32'(ebusy));
      chk("mul_gx", 32'(bus.mul_gx), 32'(emx));
      chk("mul_gy", 32'(bus.mul_gy), 32'(emy));
      chk("mul_ex", 32'(bus.mul_ex), 32'(eme));
      chk("mul_ey", 32'(bus.mul_ey), 32'(emf));
   endtask

   task automatic idle(input int n, input logic ebusy);
      for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0, 22'd0, ebusy);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_in  = 1'b0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
      bus.req0_gx = '0; bus.req0_gy = '0; bus.req0_ex = '0; bus.req0_ey = '0;
      bus.req1_gx = '0; bus.req1_gy = '0; bus.req1_ex = '0; bus.req1_ey = '0;
      emx = '0; emy = '0; eme = '0; emf = '0;

      // ---- reset state
      @(negedge clk_in);
      @(negedge clk_in);
      chk("rst_mul_gx", 32'(bus.mul_gx), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 0);
      chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 0);
      chk("rst_rsp0_product", 32'(bus.rsp0_product), 0);
      rst_in = 1'b1;

      // ---- single request: 10 * 2 = 20
      set0(11'b1010, 11'b0010, 5'd1, 5'd2);
      run_cycle(1, 0, 1, 0, 0, 0, 22'd0, 1);
      idle(3, 1);
      run_cycle(0, 0, 0, 0, 1, 0, 22'd20, 1);
      idle(1, 0);

      // ---- contention: grants 0,1,0,1,0,1; 7*9=63 for req0, 3*5=15 for req1
      set0(11'd7, 11'd9, 5'd3, 5'd4);
      set1(11'd3, 11'd5, 5'd5, 5'd6);
      run_cycle(1, 1, 1, 0, 0, 0, 22'd0, 1);
      run_cycle(1, 1, 0, 1, 0, 0, 22'd0, 1);
      run_cycle(1, 1, 1, 0, 0, 0, 22'd0, 1);
      run_cycle(1, 1, 0, 1, 0, 0, 22'd0, 1);
      run_cycle(1, 1, 1, 0, 1, 0, 22'd63, 1);
      run_cycle(1, 1, 0, 1, 0, 1, 22'd15, 1);
      run_cycle(0, 0, 0, 0, 1, 0, 22'd63, 1);
      run_cycle(0, 0, 0, 0, 0, 1, 22'd15, 1);
      run_cycle(0, 0, 0, 0, 1, 0, 22'd63, 1);
      run_cycle(0, 0, 0, 0, 0, 1, 22'd15, 1);
      idle(1, 0);

      // ---- req1 streaming, distinct operands: 6, 20, 42, 72
      set1(11'd2, 11'd3, 5'd1, 5'd1);  run_cycle(0, 1, 0, 1, 0, 0, 22'd0, 1);
      set1(11'd4, 11'd5, 5'd2, 5'd3);  run_cycle(0, 1, 0, 1, 0, 0, 22'd0, 1);
      set1(11'd6, 11'd7, 5'd4, 5'd5);  run_cycle(0, 1, 0, 1, 0, 0, 22'd0, 1);
      set1(11'd8, 11'd9, 5'd6, 5'd7);  run_cycle(0, 1, 0, 1, 0, 0, 22'd0, 1);
      run_cycle(0, 0, 0, 0, 0, 1, 22'd6, 1);
      run_cycle(0, 0, 0, 0, 0, 1, 22'd20, 1);
      run_cycle(0, 0, 0, 0, 0, 1, 22'd42, 1);
      run_cycle(0, 0, 0, 0, 0, 1, 22'd72, 1);
      idle(1, 0);

      // ---- hold: pointer still favours req0; req1 waits one cycle
      set0(11'd11, 11'd11, 5'd1, 5'd1);
      set1(11'd12, 11'd12, 5'd2, 5'd2);
      run_cycle(1, 1, 1, 0, 0, 0, 22'd0, 1);
      run_cycle(0, 1, 0, 1, 0, 0, 22'd0, 1);
      idle(2, 1);
      run_cycle(0, 0, 0, 0, 1, 0, 22'd121, 1);
      run_cycle(0, 0, 0, 0, 0, 1, 22'd144, 1);
      idle(1, 0);

      // ---- gaps: req0, req1, req0 -> 25, 36, 100
      set0(11'd5, 11'd5, 5'd9, 5'd8);   run_cycle(1, 0, 1, 0, 0, 0, 22'd0, 1);
      set1(11'd6, 11'd6, 5'd7, 5'd6);   run_cycle(0, 1, 0, 1, 0, 0, 22'd0, 1);
      set0(11'd10, 11'd10, 5'd3, 5'd2); run_cycle(1, 0, 1, 0, 0, 0, 22'd0, 1);
      idle(1, 1);
      run_cycle(0, 0, 0, 0, 1, 0, 22'd25, 1);
      run_cycle(0, 0, 0, 0, 0, 1, 22'd36, 1);
      run_cycle(0, 0, 0, 0, 1, 0, 22'd100, 1);
      idle(1, 0);

      // ---- pointer moved by the hold contention: now req1 wins (13*2=26)
      set0(11'd1, 11'd1, 5'd0, 5'd0);
      set1(11'd13, 11'd2, 5'd31, 5'd30);
      run_cycle(1, 1, 0, 1, 0, 0, 22'd0, 1);
      idle(3, 1);
      run_cycle(0, 0, 0, 0, 0, 1, 22'd26, 1);
      idle(1, 0);

      // ---- reset with three operations in flight
      set0(11'd3, 11'd4, 5'd1, 5'd1);
      run_cycle(1, 0, 1, 0, 0, 0, 22'd0, 1);
      run_cycle(1, 0, 1, 0, 0, 0, 22'd0, 1);
      run_cycle(1, 0, 1, 0, 0, 0, 22'd0, 1);
      bus.req0_valid = 1'b0;
      rst_in = 1'b0;
      #1;
      chk("mid_rst_mul_gx", 32'(bus.mul_gx), 0);
      chk("mid_rst_mul_gy", 32'(bus.mul_gy), 0);
      chk("mid_rst_mul_ex", 32'(bus.mul_ex), 0);
      chk("mid_rst_mul_ey", 32'(bus.mul_ey), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_rsp0_product", 32'(bus.rsp0_product), 0);
      chk("mid_rst_rsp1_product", 32'(bus.rsp1_product), 0);
      @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      emx = '0; emy = '0; eme = '0; emf = '0;
      idle(6, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
